sa_fifo_ctrl_160x65: RTL and testbench

//  Valid/ready FIFO controller that owns the write and read ports of a 160x65 two-port RAM

---
 rtl/sa_fifo_ctrl_160x65_pkg.sv | 18 +
 rtl/sa_fifo_skid.sv | 55 +++++
 rtl/sa_fifo_ctrl_160x65.sv | 117 +++++++++++
 tb/tb_sa_fifo_ctrl_160x65.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sa_fifo_ctrl_160x65_pkg.sv
// Shared constants and pointer helper for the 160x65 FIFO controller and its skid buffer.
package sa_fifo_ctrl_160x65_pkg;

  localparam int WIDTH      = 65;
  localparam int DEPTH      = 160;
  localparam int AW         = 8;
  localparam int SKID_DEPTH = 3;
  localparam int CNT_W      = 8;
  localparam int SKID_AW    = 2;
  localparam int SKID_CW    = 2;
  localparam int CREDIT_W   = 3;

  // RAM pointers wrap at DEPTH-1, not at the natural 2^AW boundary.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

endpackage

// File: rtl/sa_fifo_skid.sv
// Small register FIFO absorbing RAM read data; head is presented combinationally.
module sa_fifo_skid
  import sa_fifo_ctrl_160x65_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_din,
  input  logic               i_pop,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_dout,
  output logic [SKID_CW-1:0] o_cnt
);

  logic [WIDTH-1:0]   r_mem [SKID_DEPTH];
  logic [SKID_AW-1:0] r_head;
  logic [SKID_AW-1:0] r_tail;
  logic [SKID_CW-1:0] r_cnt;
  logic               w_pop;

  function automatic logic [SKID_AW-1:0] skid_next(input logic [SKID_AW-1:0] p);
    return (p == SKID_AW'(SKID_DEPTH - 1)) ? '0 : p + SKID_AW'(1);
  endfunction

  assign w_pop = i_pop && (r_cnt != '0);

  // NOTE: storage carries no reset; only occupancy is reset, and stale
  // entries are never visible because o_valid follows the count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_din;
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_tail <= skid_next(r_tail);
      if (w_pop)  r_head <= skid_next(r_head);
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + SKID_CW'(1);
        2'b01:   r_cnt <= r_cnt - SKID_CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_valid = (r_cnt != '0);
  assign o_dout  = r_mem[r_head];
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/sa_fifo_ctrl_160x65.sv
// Valid/ready FIFO controller driving a 160x65 two-port RAM with 2-cycle read latency,
// hiding that latency behind a credit-managed output skid buffer.
module sa_fifo_ctrl_160x65
  import sa_fifo_ctrl_160x65_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [7:0]       fifo_cnt,
  output logic             fifo_idle
);

  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]    r_ram_cnt;
  logic [CNT_W-1:0]    r_fifo_cnt;
  logic [1:0]          r_inflight;
  logic                r_ore;
  logic                r_dvld;

  logic                w_wr_acc;
  logic                w_issue;
  logic                w_pop;
  logic                w_push;
  logic [SKID_CW-1:0]  w_skid_cnt;
  logic [CREDIT_W-1:0] w_credit_used;
  logic [CNT_W-1:0]    w_ram_cnt_nxt;
  logic [CNT_W-1:0]    w_fifo_cnt_nxt;
  logic [1:0]          w_inflight_nxt;

  assign wr_prdy  = (r_ram_cnt != CNT_W'(DEPTH));
  assign w_wr_acc = wr_pvld && wr_prdy;
  assign w_pop    = rd_pvld && rd_prdy;
  assign w_push   = r_dvld;

  // Credit from registered counts only: a pop frees a slot for the following cycle.
  assign w_credit_used = CREDIT_W'(r_inflight) + CREDIT_W'(w_skid_cnt);
  assign w_issue       = (r_ram_cnt != '0) && (w_credit_used < CREDIT_W'(SKID_DEPTH));

  assign ram_we  = w_wr_acc;
  assign ram_wa  = r_wr_ptr;
  assign ram_di  = wr_pd;
  assign ram_re  = w_issue;
  assign ram_ra  = r_rd_ptr;
  assign ram_ore = r_ore;

  // NOTE: every combinational output gets a default first so no path holds
  // a previous value and infers a latch.
  always_comb begin
    w_ram_cnt_nxt  = r_ram_cnt;
    w_fifo_cnt_nxt = r_fifo_cnt;
    w_inflight_nxt = r_inflight;
    case ({w_wr_acc, w_issue})
      2'b10:   w_ram_cnt_nxt = r_ram_cnt + CNT_W'(1);
      2'b01:   w_ram_cnt_nxt = r_ram_cnt - CNT_W'(1);
      default: ;
    endcase
    case ({w_wr_acc, w_pop})
      2'b10:   w_fifo_cnt_nxt = r_fifo_cnt + CNT_W'(1);
      2'b01:   w_fifo_cnt_nxt = r_fifo_cnt - CNT_W'(1);
      default: ;
    endcase
    case ({w_issue, w_push})
      2'b10:   w_inflight_nxt = r_inflight + 2'd1;
      2'b01:   w_inflight_nxt = r_inflight - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_fifo_cnt <= '0;
      r_inflight <= '0;
      r_ore      <= 1'b0;
      r_dvld     <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_issue)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_fifo_cnt <= w_fifo_cnt_nxt;
      r_inflight <= w_inflight_nxt;
      // ram_ore strobes the RAM output register once per issued read; r_dvld marks valid ram_dout.
      r_ore      <= w_issue;
      r_dvld     <= r_ore;
    end
  end

  sa_fifo_skid u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_din   (ram_dout),
    .i_pop   (w_pop),
    .o_valid (rd_pvld),
    .o_dout  (rd_pd),
    .o_cnt   (w_skid_cnt)
  );

  assign fifo_cnt  = r_fifo_cnt;
  assign fifo_idle = (r_fifo_cnt == '0);

endmodule

// File: tb/tb_sa_fifo_ctrl_160x65.sv
// Scoreboard bench for sa_fifo_ctrl_160x65 with a behavioural 160x65 two-port RAM on the ram_* pins.
module tb_sa_fifo_ctrl_160x65;
  import sa_fifo_ctrl_160x65_pkg::*;

  typedef logic [WIDTH-1:0] word_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  word_t       wr_pd, rd_pd, ram_di, ram_dout;
  logic [7:0]  ram_wa, ram_ra, fifo_cnt;
  logic        ram_we, ram_re, ram_ore, fifo_idle;

  int n_checks = 0;
  int n_fails  = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  word_t sb[$];

  always #5 clk = ~clk;

  sa_fifo_ctrl_160x65 dut (
    .clk(clk), .rstn(rstn),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
    .fifo_cnt(fifo_cnt), .fifo_idle(fifo_idle)
  );

  // RAM model: registered read address, output register loaded only when ram_ore=1.
  word_t      ram_m [DEPTH];
  logic [7:0] ra_q;
  word_t      dout_q;
  always @(posedge clk) begin
    if (ram_we)  ram_m[ram_wa] <= ram_di;
    if (ram_re)  ra_q <= ram_ra;
    if (ram_ore) dout_q <= ram_m[ra_q];
  end
  assign ram_dout = dout_q;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] wrap_inc(input logic [7:0] p);
    return (p == 8'd159) ? 8'd0 : p + 8'd1;
  endfunction

  // Per-cycle monitor on the falling edge, away from the active edge.
  logic       prev_re = 1'b0, prev_stall = 1'b0;
  word_t      prev_pd;
  logic [7:0] exp_wa = '0, exp_ra = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      prev_re = 1'b0; prev_stall = 1'b0; exp_wa = '0; exp_ra = '0;
    end else begin
      check("fifo_cnt", word_t'(fifo_cnt), word_t'(sb.size()));
      check("fifo_idle", word_t'(fifo_idle), word_t'(sb.size() == 0));
      check("ore_after_re", word_t'(ram_ore), word_t'(prev_re));
      check("credit_bound", word_t'(int'(dut.r_inflight) + int'(dut.w_skid_cnt) <= SKID_DEPTH), word_t'(1));
      if (wr_pvld && wr_prdy) begin
        check("ram_we", word_t'(ram_we), word_t'(1));
        check("ram_wa", word_t'(ram_wa), word_t'(exp_wa));
        check("ram_di", ram_di, wr_pd);
        sb.push_back(wr_pd);
        exp_wa = wrap_inc(exp_wa);
        n_acc++;
      end else begin
        check("ram_we_idle", word_t'(ram_we), word_t'(0));
      end
      if (ram_re) begin
        check("ram_ra", word_t'(ram_ra), word_t'(exp_ra));
        exp_ra = wrap_inc(exp_ra);
      end
      if (prev_stall) begin
        check("rd_hold_vld", word_t'(rd_pvld), word_t'(1));
        check("rd_hold_pd", rd_pd, prev_pd);
      end
      if (rd_pvld && rd_prdy) begin
        if (sb.size() == 0) check("rd_underflow", word_t'(rd_pvld), word_t'(0));
        else check("rd_data", rd_pd, sb.pop_front());
        n_pop++;
      end
      prev_stall = rd_pvld && !rd_prdy;
      prev_pd    = rd_pd;
      prev_re    = ram_re;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input word_t d, output int waits);
    waits   = 0;
    wr_pvld = 1'b1;
    wr_pd   = d;
    while (!wr_prdy && waits < 1000) begin tick(); waits++; end
    if (!wr_prdy) check("send_timeout", word_t'(wr_prdy), word_t'(1));
    tick();
    wr_pvld = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    while ((sb.size() != 0 || !fifo_idle) && b < 2000) begin tick(); b++; end
    check("drain_idle", word_t'(fifo_idle), word_t'(1));
    check("drain_sb_empty", word_t'(sb.size()), word_t'(0));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stalls, p0, a0, idx, cyc;
    logic acc;
    word_t wd;
    rstn = 1'b0; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_prdy", word_t'(wr_prdy), word_t'(1));
    check("rst_rd_pvld", word_t'(rd_pvld), word_t'(0));
    check("rst_ram_re", word_t'(ram_re), word_t'(0));
    check("rst_ram_ore", word_t'(ram_ore), word_t'(0));
    check("rst_idle", word_t'(fifo_idle), word_t'(1));
    tick(); rstn = 1'b1;

    // 1: single word latency
    tick();
    wr_pvld = 1'b1; wr_pd = 65'h1_2345_6789_ABCD; rd_prdy = 1'b1; #1;
    check("t1_c0_we", word_t'(ram_we), word_t'(1));
    check("t1_c0_re", word_t'(ram_re), word_t'(0));
    tick(); wr_pvld = 1'b0; #1;
    check("t1_c1_re", word_t'(ram_re), word_t'(1));
    check("t1_c1_ore", word_t'(ram_ore), word_t'(0));
    tick(); #1;
    check("t1_c2_ore", word_t'(ram_ore), word_t'(1));
    check("t1_c2_re", word_t'(ram_re), word_t'(0));
    tick(); #1;
    check("t1_c3_pvld", word_t'(rd_pvld), word_t'(0));
    tick(); #1;
    check("t1_c4_pvld", word_t'(rd_pvld), word_t'(1));
    check("t1_c4_pd", rd_pd, 65'h1_2345_6789_ABCD);
    tick(); #1;
    check("t1_c5_idle", word_t'(fifo_idle), word_t'(1));
    check("t1_c5_pvld", word_t'(rd_pvld), word_t'(0));

    // 2: fill to DEPTH+SKID_DEPTH with consumer stalled, then drain in order
    rd_prdy = 1'b0;
    for (int i = 0; i < 163; i++) send(word_t'(i), w);
    check("t2_prdy_low", word_t'(wr_prdy), word_t'(0));
    repeat (6) tick();
    check("t2_cnt", word_t'(fifo_cnt), word_t'(163));
    check("t2_prdy_still_low", word_t'(wr_prdy), word_t'(0));
    check("t2_pvld", word_t'(rd_pvld), word_t'(1));
    check("t2_head", rd_pd, word_t'(0));
    drain();

    // 3: streaming 500 words across several pointer wraps
    rd_prdy = 1'b1; stalls = 0; p0 = n_pop;
    for (int i = 0; i < 500; i++) begin
      send({1'b1, 32'hA5A5_0000 + 32'(i), 32'(i * 7)}, w);
      stalls += w;
    end
    check("t3_wr_stalls", word_t'(stalls), word_t'(0));
    drain();
    check("t3_pops", word_t'(n_pop - p0), word_t'(500));

    // 4: random valid/ready traffic
    idx = 0; cyc = 0; p0 = n_pop;
    wd = {1'($urandom), $urandom, $urandom};
    while (idx < 10000 && cyc < 60000) begin
      wr_pvld = 1'($urandom_range(1, 0));
      rd_prdy = ($urandom_range(9, 0) < 3);
      wr_pd   = wd;
      acc     = wr_pvld && wr_prdy;
      tick(); cyc++;
      if (acc) begin idx++; wd = {1'($urandom), $urandom, $urandom}; end
    end
    check("t4_words", word_t'(idx), word_t'(10000));
    drain();
    check("t4_pops", word_t'(n_pop - p0), word_t'(10000));

    // 5: full FIFO, one pop lets exactly one later write in
    rd_prdy = 1'b0;
    for (int i = 0; i < 163; i++) send(word_t'(1000 + i), w);
    repeat (6) tick();
    check("t5_full_cnt", word_t'(fifo_cnt), word_t'(163));
    p0 = n_pop; a0 = n_acc;
    wr_pvld = 1'b1; wr_pd = word_t'(77777); rd_prdy = 1'b1;
    tick(); rd_prdy = 1'b0;
    check("t5_prdy_not_yet", word_t'(wr_prdy), word_t'(0));
    for (int k = 0; k < 10; k++) begin
      acc = wr_pvld && wr_prdy;
      tick();
      if (acc) wr_pvld = 1'b0;
    end
    wr_pvld = 1'b0;
    check("t5_one_accept", word_t'(n_acc - a0), word_t'(1));
    check("t5_one_pop", word_t'(n_pop - p0), word_t'(1));
    check("t5_cnt_back", word_t'(fifo_cnt), word_t'(163));
    check("t5_prdy_low", word_t'(wr_prdy), word_t'(0));
    drain();

    // 6: reset with reads in flight
    rd_prdy = 1'b0;
    for (int i = 0; i < 4; i++) send(word_t'(16'hBEE0 + i), w);
    rstn = 1'b0; #1;
    check("t6_rst_pvld", word_t'(rd_pvld), word_t'(0));
    check("t6_rst_cnt", word_t'(fifo_cnt), word_t'(0));
    check("t6_rst_prdy", word_t'(wr_prdy), word_t'(1));
    check("t6_rst_ore", word_t'(ram_ore), word_t'(0));
    tick(); rstn = 1'b1; rd_prdy = 1'b1;
    repeat (5) tick();
    check("t6_no_ghost", word_t'(rd_pvld), word_t'(0));
    p0 = n_pop;
    send(word_t'(8'h55), w);
    drain();
    check("t6_one_word", word_t'(n_pop - p0), word_t'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
